// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the sequencer states, per-stage control bundle and the canned control patterns.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SLEEP,
        WAKE
    } pctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register enables and bubble inserts for PC and the four pipeline registers
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

    // Everything frozen
    localparam stage_ctrl_t CTRL_HOLD       = 7'b00000_00;
    // Normal advance
    localparam stage_ctrl_t CTRL_GO         = 7'b11111_00;
    // Redirect: advance and squash both front-end stages
    localparam stage_ctrl_t CTRL_FLUSH      = 7'b11111_11;
    // Front end frozen, bubble into EX, back end advances
    localparam stage_ctrl_t CTRL_BUBBLE     = 7'b00111_01;
    // Draining but memory is waiting: freeze, keep bubbling EX
    localparam stage_ctrl_t CTRL_DRAIN_HOLD = 7'b00000_01;
    // Frozen with both front-end stages squashed
    localparam stage_ctrl_t CTRL_SQUASH     = 7'b00000_11;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Ports: id_ex_memread, rs1, rs2, rd in; hazard out (combinational).
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_ex_memread,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       hazard
);

    logic src_match;

    assign src_match = (rd == rs1) || (rd == rs2);

    // x0 is never really written, so a load into x0 cannot create a dependency
    assign hazard = id_ex_memread && (rd != REG_ZERO) && src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges memory waits, load-use, redirects and WFI sleep.
// Ports: clk, rst (async active-low); hazard/event inputs; stage enables, flushes,
//        load_use_hazard, delay_hazard, wfi_sleep and saturating stall_cycles out.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_stall,
    input  logic             dm_stall,
    input  logic             id_ex_memread,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    input  logic             wfi_ex,
    input  logic             irq_wake,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             load_use_hazard,
    output logic             delay_hazard,
    output logic             wfi_sleep,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pctrl_state_t     state_q;
    pctrl_state_t     state_d;
    logic             flush_pend_q;
    logic             flush_pend_d;
    logic [2:0]       drain_cnt_q;
    logic [2:0]       drain_cnt_d;
    logic             delay_hazard_q;
    logic [CNT_W-1:0] stall_q;

    stage_ctrl_t      ctrl;
    stage_ctrl_t      ctrl_out;
    logic             sleep_c;
    logic             gstall;
    logic             luh;

    load_use_detect u_luh (
        .id_ex_memread (id_ex_memread),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .hazard        (luh)
    );

    assign gstall = im_stall | dm_stall;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        drain_cnt_d  = drain_cnt_q;
        ctrl         = CTRL_HOLD;
        sleep_c      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (gstall) begin
                    // Redirect cannot land while frozen; remember it
                    ctrl = CTRL_HOLD;
                    if (branch_taken) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (branch_taken || flush_pend_q) begin
                    // Squashes ID, so any load-use there is moot
                    ctrl         = CTRL_FLUSH;
                    flush_pend_d = 1'b0;
                end else if (wfi_ex) begin
                    ctrl        = CTRL_BUBBLE;
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = DRAIN;
                end else if (luh) begin
                    ctrl = CTRL_BUBBLE;
                end else begin
                    ctrl = CTRL_GO;
                end
            end

            DRAIN: begin
                ctrl = gstall ? CTRL_DRAIN_HOLD : CTRL_BUBBLE;
                if (!gstall) begin
                    if (drain_cnt_q == 3'd0) begin
                        state_d = irq_wake ? WAKE : SLEEP;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 3'd1;
                    end
                end
            end

            SLEEP: begin
                ctrl    = CTRL_HOLD;
                sleep_c = 1'b1;
                if (irq_wake) begin
                    state_d = WAKE;
                end
            end

            WAKE: begin
                // Restart fetch with both front-end stages cleared
                ctrl = gstall ? CTRL_SQUASH : CTRL_FLUSH;
                if (!gstall) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // While reset is held the whole pipe is frozen with bubbles forced in
    assign ctrl_out = rst ? ctrl : CTRL_SQUASH;

    assign pc_en           = ctrl_out.pc_en;
    assign if_id_en        = ctrl_out.if_id_en;
    assign id_ex_en        = ctrl_out.id_ex_en;
    assign ex_mem_en       = ctrl_out.ex_mem_en;
    assign mem_wb_en       = ctrl_out.mem_wb_en;
    assign if_id_flush     = ctrl_out.if_id_flush;
    assign id_ex_flush     = ctrl_out.id_ex_flush;
    assign wfi_sleep       = rst & sleep_c;
    assign load_use_hazard = luh;
    assign delay_hazard    = delay_hazard_q;
    assign stall_cycles    = stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            drain_cnt_q  <= 3'd0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_hazard_q <= 1'b0;
        end else if (!gstall) begin
            delay_hazard_q <= luh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (!ctrl.pc_en && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, corner sequences, random vs model.
// A second instance with a 4-bit counter covers saturation.
module tb_pipeline_ctrl;

    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic rst;
    logic im_stall, dm_stall, id_ex_memread;
    logic [4:0] rs1, rs2, rd;
    logic branch_taken, wfi_ex, irq_wake;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, load_use_hazard, delay_hazard, wfi_sleep;
    logic [31:0] stall_cycles;

    logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic s_if_id_flush, s_id_ex_flush, s_luh, s_dh, s_sleep;
    logic [3:0] s_stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32), .DRAIN_CYC(DRAIN)) u_dut (
        .clk(clk), .rst(rst),
        .im_stall(im_stall), .dm_stall(dm_stall),
        .id_ex_memread(id_ex_memread),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .branch_taken(branch_taken), .wfi_ex(wfi_ex), .irq_wake(irq_wake),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .load_use_hazard(load_use_hazard), .delay_hazard(delay_hazard),
        .wfi_sleep(wfi_sleep), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.CNT_W(4), .DRAIN_CYC(DRAIN)) u_sat (
        .clk(clk), .rst(rst),
        .im_stall(im_stall), .dm_stall(dm_stall),
        .id_ex_memread(id_ex_memread),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .branch_taken(branch_taken), .wfi_ex(wfi_ex), .irq_wake(irq_wake),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .load_use_hazard(s_luh), .delay_hazard(s_dh),
        .wfi_sleep(s_sleep), .stall_cycles(s_stall)
    );

    wire [6:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush};
    wire [6:0] s_ctl = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en,
                        s_mem_wb_en, s_if_id_flush, s_id_ex_flush};

    // Reference model: what the sequencer is doing, in plain terms
    bit     m_pend;
    bit     m_drain;
    bit     m_sleep;
    bit     m_wake;
    int     m_left;
    bit     m_dh;
    longint m_cnt;
    longint m_cnt4;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    task automatic model_check(input string tag);
        logic lu, gs, sl, pc;
        logic [6:0] e;
        bit np, nd, ns, nw, ndh;
        int nl;
        lu = id_ex_memread && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        gs = im_stall || dm_stall;
        np = m_pend; nd = m_drain; ns = m_sleep; nw = m_wake;
        nl = m_left; ndh = m_dh; sl = 1'b0;
        if (m_sleep) begin
            e = 7'b0000000; sl = 1'b1;
            if (irq_wake) begin ns = 0; nw = 1; end
        end else if (m_wake) begin
            e = gs ? 7'b0000011 : 7'b1111111;
            if (!gs) nw = 0;
        end else if (m_drain) begin
            e = gs ? 7'b0000001 : 7'b0011101;
            if (!gs) begin
                nl = m_left - 1;
                if (nl == 0) begin
                    nd = 0;
                    if (irq_wake) nw = 1; else ns = 1;
                end
            end
        end else if (gs) begin
            e = 7'b0000000;
            if (branch_taken) np = 1;
        end else if (branch_taken || m_pend) begin
            e = 7'b1111111; np = 0;
        end else if (wfi_ex) begin
            e = 7'b0011101; nd = 1; nl = DRAIN;
        end else if (lu) begin
            e = 7'b0011101;
        end else begin
            e = 7'b1111100;
        end
        if (!gs) ndh = lu;
        pc = e[6];
        if (!rst) begin
            e = 7'b0000011; sl = 1'b0;
        end
        chk({tag, ".ctl"}, 64'(ctl), 64'(e));
        chk({tag, ".sctl"}, 64'(s_ctl), 64'(e));
        chk({tag, ".luh"}, 64'(load_use_hazard), 64'(lu));
        chk({tag, ".sleep"}, 64'(wfi_sleep), 64'(sl));
        chk({tag, ".dh"}, 64'(delay_hazard), rst ? 64'(m_dh) : 64'd0);
        chk({tag, ".cnt"}, 64'(stall_cycles), rst ? 64'(m_cnt) : 64'd0);
        chk({tag, ".cnt4"}, 64'(s_stall), rst ? 64'(m_cnt4) : 64'd0);
        if (!rst) begin
            m_pend = 0; m_drain = 0; m_sleep = 0; m_wake = 0;
            m_left = 0; m_dh = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            m_pend = np; m_drain = nd; m_sleep = ns; m_wake = nw;
            m_left = nl; m_dh = ndh;
            if (!pc) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic advance(input string tag);
        model_check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        settle();
        advance(tag);
    endtask

    task automatic idle();
        im_stall = 0; dm_stall = 0; id_ex_memread = 0;
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        branch_taken = 0; wfi_ex = 0; irq_wake = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step("rst0");
        step("rst1");
        rst = 1'b1;
    endtask

    typedef struct {
        logic       im, dm, mr;
        logic [4:0] r1, r2, d;
        logic       br;
        logic [6:0] ctl;
        logic       luh;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 7'b1111100, 0};
        vt[1] = '{0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 7'b0011101, 1};
        vt[2] = '{0, 0, 1, 5'd1, 5'd7, 5'd7, 0, 7'b0011101, 1};
        vt[3] = '{0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 7'b1111100, 0};
        vt[4] = '{0, 0, 0, 5'd5, 5'd0, 5'd5, 0, 7'b1111100, 0};
        vt[5] = '{0, 0, 1, 5'd5, 5'd4, 5'd6, 0, 7'b1111100, 0};
        vt[6] = '{1, 0, 0, 5'd1, 5'd2, 5'd3, 0, 7'b0000000, 0};
        vt[7] = '{0, 1, 1, 5'd9, 5'd2, 5'd9, 0, 7'b0000000, 1};
        vt[8] = '{0, 0, 1, 5'd4, 5'd4, 5'd4, 1, 7'b1111111, 1};
        vt[9] = '{0, 0, 0, 5'd1, 5'd2, 5'd3, 1, 7'b1111111, 0};

        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        step("rst0");
        step("rst1");
        rst = 1'b1;

        // Single-cycle vectors from a clean RUN state
        for (int i = 0; i < 10; i++) begin
            idle();
            im_stall = vt[i].im; dm_stall = vt[i].dm;
            id_ex_memread = vt[i].mr;
            rs1 = vt[i].r1; rs2 = vt[i].r2; rd = vt[i].d;
            branch_taken = vt[i].br;
            settle();
            chk($sformatf("vec%0d.ctl", i), 64'(ctl), 64'(vt[i].ctl));
            chk($sformatf("vec%0d.luh", i), 64'(load_use_hazard),
                64'(vt[i].luh));
            advance($sformatf("vec%0d", i));
        end

        // Load-use then delay_hazard; rd=x0 never stalls
        do_reset();
        idle();
        id_ex_memread = 1; rd = 5'd5; rs1 = 5'd5;
        step("lu");
        idle();
        settle();
        chk("lu.dh_next", 64'(delay_hazard), 64'd1);
        advance("lu_after");
        id_ex_memread = 1; rd = 5'd0; rs1 = 5'd0;
        settle();
        chk("lu0.pc_en", 64'(pc_en), 64'd1);
        advance("lu0");

        // Redirect arriving during a 3-cycle fetch stall
        idle();
        im_stall = 1; branch_taken = 1;
        step("rd1");
        branch_taken = 0;
        step("rd2");
        step("rd3");
        im_stall = 0;
        settle();
        chk("redir.flush", 64'({if_id_flush, id_ex_flush}), 64'd3);
        advance("rd4");
        settle();
        chk("redir.cleared", 64'({if_id_flush, id_ex_flush}), 64'd0);
        advance("rd5");

        // WFI -> DRAIN x2 -> SLEEP x10 -> WAKE -> RUN
        do_reset();
        idle();
        wfi_ex = 1;
        step("wfi");
        wfi_ex = 0;
        step("drn1");
        step("drn2");
        for (int i = 0; i < 10; i++) begin
            irq_wake = (i == 9);
            settle();
            chk("sleep.flag", 64'(wfi_sleep), 64'd1);
            advance("slp");
        end
        irq_wake = 0;
        settle();
        chk("wake.ctl", 64'(ctl), 64'h7F);
        advance("wake");
        settle();
        chk("wake.cnt13", 64'(stall_cycles), 64'd13);
        advance("run");

        // WFI with data memory wait inside DRAIN stretches it to 4 cycles
        do_reset();
        idle();
        wfi_ex = 1;
        step("wfi2");
        wfi_ex = 0;
        step("d1");
        dm_stall = 1;
        settle();
        chk("drain.exmem_hold", 64'(ex_mem_en), 64'd0);
        advance("d2");
        step("d3");
        dm_stall = 0;
        settle();
        chk("drain.d4_awake", 64'(wfi_sleep), 64'd0);
        advance("d4");
        settle();
        chk("drain.asleep", 64'(wfi_sleep), 64'd1);
        irq_wake = 1;
        advance("s1");
        irq_wake = 0;
        step("w1");
        step("r1");

        // Counter saturation on the 4-bit instance
        do_reset();
        idle();
        im_stall = 1;
        for (int i = 0; i < 20; i++) step("sat");
        im_stall = 0;
        settle();
        chk("sat.cnt4", 64'(s_stall), 64'd15);
        chk("sat.cnt32", 64'(stall_cycles), 64'd20);
        advance("sat_end");

        // Asynchronous reset while asleep
        do_reset();
        idle();
        wfi_ex = 1;
        step("wfi3");
        wfi_ex = 0;
        step("dd1");
        step("dd2");
        settle();
        chk("ar.asleep", 64'(wfi_sleep), 64'd1);
        advance("ss1");
        #2 rst = 1'b0;
        #1;
        chk("ar.ctl", 64'(ctl), 64'h03);
        chk("ar.sleep", 64'(wfi_sleep), 64'd0);
        chk("ar.cnt", 64'(stall_cycles), 64'd0);
        step("ar_low");
        rst = 1'b1;
        settle();
        chk("ar.run", 64'(ctl), 64'h7C);
        chk("ar.cnt0", 64'(stall_cycles), 64'd0);
        advance("ar_run");

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(99) < 1) ? 1'b0 : 1'b1;
            im_stall = $urandom_range(99) < 15;
            dm_stall = $urandom_range(99) < 12;
            id_ex_memread = $urandom_range(99) < 40;
            rs1 = 5'($urandom_range(3));
            rs2 = 5'($urandom_range(3));
            rd = 5'($urandom_range(3));
            branch_taken = $urandom_range(99) < 10;
            wfi_ex = $urandom_range(99) < 6;
            irq_wake = $urandom_range(99) < 12;
            step("rnd");
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges memory-wait stalls, load-use hazards, branch/trap redirects and WFI sleep into per-stage register enables and flushes. Holds redirects that arrive during memory stalls and keeps a saturating stall-cycle performance counter. Sits beside the decode stage and drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.

Parameters:
CNT_W, 32, width of the stall-cycle counter (saturates at all-ones)
DRAIN_CYC, 2, back-end drain cycles after WFI before SLEEP (valid range 1-7)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
im_stall  in  1  instruction memory wait
dm_stall  in  1  data memory wait
id_ex_memread  in  1  EX-stage instruction is a load
rs1  in  5  ID-stage source register 1
rs2  in  5  ID-stage source register 2
rd  in  5  EX-stage destination register
branch_taken  in  1  EX-stage redirect (branch, jump, mret, trap entry)
wfi_ex  in  1  WFI instruction in EX
irq_wake  in  1  enabled interrupt pending
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
if_id_flush, id_ex_flush  out  1 each  insert bubble in the stage register
load_use_hazard  out  1  combinational load-use detect
delay_hazard  out  1  registered load_use_hazard of the last non-stalled cycle
wfi_sleep  out  1  core asleep
stall_cycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- Reset (rst low, asynchronous): state=RUN, flush_pend=0, delay_hazard=0, drain_cnt=0, stall_cycles=0. While rst is low, all enables=0, both flushes=1, wfi_sleep=0.
- load_use_hazard = id_ex_memread & (rd!=0) & ((rd==rs1)|(rd==rs2)).
- gstall = im_stall | dm_stall.
- State RUN, priority order:
  1. gstall: all enables=0, flushes=0. branch_taken sets flush_pend. delay_hazard holds.
  2. branch_taken | flush_pend: all enables=1, if_id_flush=id_ex_flush=1, flush_pend cleared. Overrides a load-use hazard because the ID instruction is squashed.
  3. wfi_ex: pc_en=0, if_id_en=0, id_ex_flush=1, other enables=1. drain_cnt=DRAIN_CYC-1. Go to DRAIN.
  4. load_use_hazard: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_en=mem_wb_en=1.
  5. Otherwise: all enables=1, flushes=0.
  - delay_hazard <= load_use_hazard on every cycle without gstall.
- State DRAIN: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=~gstall.
  - drain_cnt decrements only on cycles without gstall.
  - At 0 with no gstall: go to WAKE if irq_wake, else SLEEP.
  - branch_taken is ignored.
- State SLEEP: all enables=0, wfi_sleep=1. irq_wake goes to WAKE on the next edge.
- State WAKE: one cycle, pc_en=1, if_id_en=1, if_id_flush=id_ex_flush=1, wfi_sleep=0. If gstall, stay in WAKE with all enables=0; otherwise go to RUN.
- stall_cycles increments on every cycle with pc_en=0 (gstall, load-use, DRAIN, SLEEP, WAKE-stalled) and saturates at 2^CNT_W-1. It never wraps.
- Simultaneous events:
  - gstall with branch_taken: the redirect is deferred via flush_pend and applied on the first cycle without gstall.
  - wfi_ex with branch_taken: the redirect wins and the WFI is squashed.
  - irq_wake already high at the WFI: DRAIN still completes, then WAKE follows with no SLEEP cycle.
- Reset asserted in any state returns to RUN immediately, clearing flush_pend and drain_cnt.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} pctrl_state_t
  - localparam REG_ZERO = 5'd0
- Sub-module load_use_detect (combinational) holds the hazard compare. The delay_hazard flop and FSM stay in pipeline_ctrl.

Test Plan:
- Load-use stall: id_ex_memread=1, rd=5, rs1=5 -> load_use_hazard=1, pc_en=0, id_ex_flush=1 for 1 cycle; delay_hazard=1 next cycle. Repeat with rd=0 -> no stall.
- Redirect during stall: im_stall=1 for 3 cycles with branch_taken pulsed in cycle 1 -> all enables 0 for 3 cycles, then if_id_flush=id_ex_flush=1 in cycle 4, flush_pend cleared.
- WFI sleep/wake: wfi_ex pulse, no irq -> 2 DRAIN cycles, then wfi_sleep=1. irq_wake after 10 cycles -> WAKE 1 cycle with flushes=1, then RUN; stall_cycles=13.
- WFI with dm_stall=1 during DRAIN for 2 cycles -> DRAIN lasts 4 cycles; ex_mem_en=0 while stalled.
- Counter saturation: CNT_W=4, hold im_stall for 20 cycles -> stall_cycles stops at 15.
- Async reset in SLEEP: rst low mid-cycle -> outputs immediately enables=0, flushes=1, wfi_sleep=0; after release, state=RUN and stall_cycles=0.
